// File: rtl/pcie_bench_pkg.sv
// Shared types and helpers for the PCIe stream arbitration blocks.
package pcie_bench_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_e;

    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    // Channel index width; a single channel still needs one bit.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pcie_axis_skid.sv
// Two-entry skid buffer: registered outputs, full throughput, and an
// input ready that never depends combinationally on the output ready.
module pcie_axis_skid #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] skid_data;
    logic         skid_valid;
    logic         in_fire;

    assign in_fire = in_valid & in_ready;

    // The skid slot only fills when the output register is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            in_ready   <= 1'b1;
        end else if (!out_valid || out_ready) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= in_fire;
                if (in_fire) begin
                    out_data <= in_data;
                end
            end
            in_ready <= 1'b1;
        end else if (in_fire) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
            in_ready   <= 1'b0;
        end
    end

endmodule

// File: rtl/pcie_c2s_stream_arbiter.sv
// Merges N application c2s AXI4-Stream sources onto the single controller
// stream with packet-granular arbitration and per-channel packet counters.
module pcie_c2s_stream_arbiter
    import pcie_bench_pkg::*;
#(
    parameter int unsigned N_CHAN  = 4,
    parameter int unsigned DATA_W  = 256,
    parameter int unsigned KEEP_W  = DATA_W / 8,
    parameter int unsigned CH_W    = ch_width(N_CHAN),
    parameter int unsigned RR_MODE = ARB_RR,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                       pcie_clk,
    input  logic                       pcie_reset,
    input  logic [N_CHAN-1:0]          in_tvalid,
    output logic [N_CHAN-1:0]          in_tready,
    input  logic [N_CHAN*DATA_W-1:0]   in_tdata,
    input  logic [N_CHAN*KEEP_W-1:0]   in_tkeep,
    input  logic [N_CHAN-1:0]          in_tlast,
    input  logic [N_CHAN-1:0]          chan_en,
    input  logic                       cnt_clear,
    output logic                       c2s_tvalid,
    input  logic                       c2s_tready,
    output logic [DATA_W-1:0]          c2s_tdata,
    output logic [KEEP_W-1:0]          c2s_tkeep,
    output logic                       c2s_tlast,
    output logic [CH_W-1:0]            c2s_tid,
    output logic [N_CHAN*CNT_W-1:0]    pkt_cnt,
    output logic                       busy
);

    localparam int unsigned PAY_W = DATA_W + KEEP_W + 1 + CH_W;

    arb_state_e        state;
    logic [CH_W-1:0]   grant;
    logic [CH_W-1:0]   last_grant;
    logic [CH_W-1:0]   pick;
    logic [CH_W-1:0]   cidx;
    logic [N_CHAN-1:0] xfer_mask;
    logic [N_CHAN-1:0] eligible;
    logic [N_CHAN-1:0] accept;
    logic              found;
    logic              last_fire;
    logic              skid_ready;
    logic              skid_valid_in;
    logic [PAY_W-1:0]  pay_in;
    logic [PAY_W-1:0]  pay_out;
    logic [CNT_W-1:0]  cnt_q [N_CHAN];
    int unsigned       idx;

    // Grant search: upward from last_grant+1 in RR mode, from 0 otherwise.
    always_comb begin
        eligible = in_tvalid & chan_en;
        pick     = '0;
        found    = 1'b0;
        idx      = 0;
        cidx     = '0;
        for (int k = 0; k < int'(N_CHAN); k++) begin
            if (RR_MODE == ARB_RR) begin
                idx = (32'(last_grant) + 32'(k) + 32'd1) % N_CHAN;
            end else begin
                idx = 32'(k);
            end
            cidx = CH_W'(idx);
            if (!found && eligible[cidx]) begin
                found = 1'b1;
                pick  = cidx;
            end
        end
    end

    assign in_tready     = xfer_mask & {N_CHAN{skid_ready}};
    assign accept        = in_tvalid & in_tready;
    assign last_fire     = |(accept & in_tlast);
    assign skid_valid_in = |(in_tvalid & xfer_mask);
    assign pay_in        = {grant,
                            in_tlast[grant],
                            in_tkeep[32'(grant)*KEEP_W +: KEEP_W],
                            in_tdata[32'(grant)*DATA_W +: DATA_W]};
    assign busy          = (state == ST_XFER);

    // Packet-level FSM; the grant is held until the tlast beat is accepted.
    always_ff @(posedge pcie_clk or posedge pcie_reset) begin
        if (pcie_reset) begin
            state      <= ST_IDLE;
            grant      <= '0;
            last_grant <= CH_W'(N_CHAN - 1);
            xfer_mask  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        state     <= ST_XFER;
                        grant     <= pick;
                        xfer_mask <= N_CHAN'(1) << pick;
                    end
                end
                ST_XFER: begin
                    if (last_fire) begin
                        state      <= ST_IDLE;
                        last_grant <= grant;
                        xfer_mask  <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Counters tick on input-side tlast acceptance; clear beats increment.
    always_ff @(posedge pcie_clk or posedge pcie_reset) begin
        if (pcie_reset) begin
            for (int i = 0; i < int'(N_CHAN); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N_CHAN); i++) begin
                if (cnt_clear) begin
                    cnt_q[i] <= '0;
                end else if (accept[i] && in_tlast[i]) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < int'(N_CHAN); g++) begin : g_cnt
        assign pkt_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end

    pcie_axis_skid #(
        .W (PAY_W)
    ) u_skid (
        .clk       (pcie_clk),
        .rst       (pcie_reset),
        .in_valid  (skid_valid_in),
        .in_ready  (skid_ready),
        .in_data   (pay_in),
        .out_valid (c2s_tvalid),
        .out_ready (c2s_tready),
        .out_data  (pay_out)
    );

    assign {c2s_tid, c2s_tlast, c2s_tkeep, c2s_tdata} = pay_out;

endmodule

// File: tb/tb_pcie_c2s_stream_arbiter.sv
// Directed bench for the c2s stream arbiter: a vector table of single packets
// plus sequences for latency, fairness, priority, enables, counters and reset.
module tb_pcie_c2s_stream_arbiter;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    in_tvalid;
    logic [3:0]    in_tlast;
    logic [1023:0] in_tdata;
    logic [127:0]  in_tkeep;
    logic [3:0]    chan_en;
    logic          cnt_clear;
    logic          c2s_tready;

    logic [3:0]    rr_in_tready, fp_in_tready;
    logic          rr_tvalid, fp_tvalid;
    logic [255:0]  rr_tdata, fp_tdata;
    logic [31:0]   rr_tkeep, fp_tkeep;
    logic          rr_tlast, fp_tlast;
    logic [1:0]    rr_tid, fp_tid;
    logic [127:0]  rr_pkt_cnt;
    logic [7:0]    fp_pkt_cnt;
    logic          rr_busy, fp_busy;

    logic          use_fp;
    logic [3:0]    obs_in_tready;
    logic          obs_tvalid, obs_tlast, obs_busy;
    logic [255:0]  obs_tdata;
    logic [31:0]   obs_tkeep;
    logic [1:0]    obs_tid;

    int total = 0;
    int bad   = 0;

    // Source model and scoreboard state
    int src_npkt[4], src_len[4], src_beat[4], src_pkt[4];
    int exp_pkt[4], exp_beat[4];
    int cur_tid, acc_in, beats_out, clear_arm, clear_hits, rdy_idx;
    int grant_log[$];
    logic [3:0]   rdy_pat;
    logic         prev_stall;
    logic [255:0] prev_data;
    logic [1:0]   prev_tid;

    typedef struct {
        int          ch;
        int          len;
        logic [3:0]  en;
        logic [3:0]  rdy;
        int          exp_beats;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    pcie_c2s_stream_arbiter #(.N_CHAN(4), .DATA_W(256), .RR_MODE(1), .CNT_W(32)) dut_rr (
        .pcie_clk   (clk),
        .pcie_reset (rst),
        .in_tvalid  (in_tvalid),
        .in_tready  (rr_in_tready),
        .in_tdata   (in_tdata),
        .in_tkeep   (in_tkeep),
        .in_tlast   (in_tlast),
        .chan_en    (chan_en),
        .cnt_clear  (cnt_clear),
        .c2s_tvalid (rr_tvalid),
        .c2s_tready (c2s_tready),
        .c2s_tdata  (rr_tdata),
        .c2s_tkeep  (rr_tkeep),
        .c2s_tlast  (rr_tlast),
        .c2s_tid    (rr_tid),
        .pkt_cnt    (rr_pkt_cnt),
        .busy       (rr_busy)
    );

    pcie_c2s_stream_arbiter #(.N_CHAN(4), .DATA_W(256), .RR_MODE(0), .CNT_W(2)) dut_fp (
        .pcie_clk   (clk),
        .pcie_reset (rst),
        .in_tvalid  (in_tvalid),
        .in_tready  (fp_in_tready),
        .in_tdata   (in_tdata),
        .in_tkeep   (in_tkeep),
        .in_tlast   (in_tlast),
        .chan_en    (chan_en),
        .cnt_clear  (cnt_clear),
        .c2s_tvalid (fp_tvalid),
        .c2s_tready (c2s_tready),
        .c2s_tdata  (fp_tdata),
        .c2s_tkeep  (fp_tkeep),
        .c2s_tlast  (fp_tlast),
        .c2s_tid    (fp_tid),
        .pkt_cnt    (fp_pkt_cnt),
        .busy       (fp_busy)
    );

    assign obs_in_tready = use_fp ? fp_in_tready : rr_in_tready;
    assign obs_tvalid    = use_fp ? fp_tvalid : rr_tvalid;
    assign obs_tdata     = use_fp ? fp_tdata : rr_tdata;
    assign obs_tkeep     = use_fp ? fp_tkeep : rr_tkeep;
    assign obs_tlast     = use_fp ? fp_tlast : rr_tlast;
    assign obs_tid       = use_fp ? fp_tid : rr_tid;
    assign obs_busy      = use_fp ? fp_busy : rr_busy;

    function automatic logic [255:0] gen_data(input int ch, input int pkt, input int beat);
        logic [255:0] d;
        d = '0;
        d[31:0]    = {8'hA0 + 8'(ch), 8'(pkt), 8'(beat), 8'h5A};
        d[255:224] = ~d[31:0];
        return d;
    endfunction

    function automatic logic [31:0] gen_keep(input int ch, input int beat);
        return 32'hFFFF_FFFF ^ 32'(beat * 3 + ch);
    endfunction

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            in_tvalid[i]            = (src_npkt[i] > 0);
            in_tlast[i]             = (src_beat[i] == src_len[i] - 1);
            in_tdata[i*256 +: 256]  = gen_data(i, src_pkt[i], src_beat[i]);
            in_tkeep[i*32 +: 32]    = gen_keep(i, src_beat[i]);
        end
    endtask

    task automatic score_beat();
        int   t;
        logic lst;
        t = int'(obs_tid);
        if (cur_tid >= 0) check("tid_held", 256'(obs_tid), 256'(cur_tid));
        else grant_log.push_back(t);
        lst = (exp_beat[t] == src_len[t] - 1);
        check("data", obs_tdata, gen_data(t, exp_pkt[t], exp_beat[t]));
        check("keep", 256'(obs_tkeep), 256'(gen_keep(t, exp_beat[t])));
        check("last", 256'(obs_tlast), 256'(lst));
        if (lst) begin
            exp_beat[t] = 0;
            exp_pkt[t]++;
            cur_tid = -1;
        end else begin
            exp_beat[t]++;
            cur_tid = t;
        end
        beats_out++;
    endtask

    // One clock: sample handshakes at negedge, advance sources after posedge.
    task automatic cycle();
        logic [3:0] fired;
        @(negedge clk);
        fired = in_tvalid & obs_in_tready;
        if (clear_arm >= 0 && fired[clear_arm] && in_tlast[clear_arm]) begin
            cnt_clear = 1'b1;
            clear_hits++;
        end
        if (prev_stall) begin
            check("stall_valid", 256'(obs_tvalid), 256'(1'b1));
            check("stall_data", obs_tdata, prev_data);
            check("stall_tid", 256'(obs_tid), 256'(prev_tid));
            check("skid_depth", 256'(acc_in - beats_out <= 2), 256'(1'b1));
        end
        prev_stall = obs_tvalid && !c2s_tready;
        prev_data  = obs_tdata;
        prev_tid   = obs_tid;
        if (obs_tvalid && c2s_tready) score_beat();
        @(posedge clk);
        #1;
        cnt_clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (fired[i]) begin
                acc_in++;
                src_beat[i]++;
                if (src_beat[i] == src_len[i]) begin
                    src_beat[i] = 0;
                    src_pkt[i]++;
                    src_npkt[i]--;
                end
            end
        end
        c2s_tready = rdy_pat[rdy_idx % 4];
        rdy_idx++;
        drive();
    endtask

    function automatic bit all_idle();
        return (src_npkt[0] + src_npkt[1] + src_npkt[2] + src_npkt[3] == 0) &&
               (acc_in == beats_out) && !obs_tvalid && !obs_busy;
    endfunction

    task automatic run_drain(input string name, input int budget);
        int n;
        n = 0;
        while (n < budget && !all_idle()) begin
            cycle();
            n++;
        end
        check({name, "_drained"}, 256'(all_idle()), 256'(1'b1));
    endtask

    task automatic run_cycles(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cnt_clear = 1'b0;
        c2s_tready = 1'b1;
        rdy_pat = 4'hF;
        rdy_idx = 0;
        chan_en = 4'hF;
        clear_arm = -1;
        clear_hits = 0;
        for (int i = 0; i < 4; i++) begin
            src_npkt[i] = 0; src_len[i] = 1; src_beat[i] = 0; src_pkt[i] = 0;
            exp_pkt[i] = 0; exp_beat[i] = 0;
        end
        cur_tid = -1;
        prev_stall = 1'b0;
        acc_in = 0;
        beats_out = 0;
        grant_log.delete();
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_log(input string name, input int exp_n, input logic [31:0] exp_ids);
        logic [31:0] ids;
        ids = exp_ids;
        check({name, "_count"}, 256'(grant_log.size()), 256'(exp_n));
        for (int k = 0; k < exp_n && k < grant_log.size(); k++) begin
            check({name, "_grant"}, 256'(grant_log[k]), 256'(ids[k*4 +: 4]));
        end
    endtask

    initial begin
        int start, n;
        use_fp = 1'b0;
        vecs[0] = '{ch: 0, len: 1, en: 4'hF,    rdy: 4'b1111, exp_beats: 1, exp_cnt: 32'd1};
        vecs[1] = '{ch: 3, len: 5, en: 4'hF,    rdy: 4'b1001, exp_beats: 5, exp_cnt: 32'd1};
        vecs[2] = '{ch: 1, len: 4, en: 4'hF,    rdy: 4'b0110, exp_beats: 4, exp_cnt: 32'd1};
        vecs[3] = '{ch: 2, len: 2, en: 4'b1011, rdy: 4'b1111, exp_beats: 0, exp_cnt: 32'd1};
        vecs[4] = '{ch: 2, len: 3, en: 4'hF,    rdy: 4'b0011, exp_beats: 3, exp_cnt: 32'd2};

        do_reset();
        check("rst_tvalid", 256'(rr_tvalid), 256'(1'b0));
        check("rst_in_tready", 256'(rr_in_tready), 256'(4'h0));
        check("rst_busy", 256'(rr_busy), 256'(1'b0));
        check("rst_tid", 256'(rr_tid), 256'(2'd0));
        check("rst_tdata", rr_tdata, 256'(0));
        check("rst_pkt_cnt", 256'(rr_pkt_cnt), 256'(0));
        check("rst_fp_tvalid", 256'(fp_tvalid), 256'(1'b0));

        // First-packet latency: arbitration cycle then skid register.
        src_npkt[2] = 1; src_len[2] = 3;
        drive();
        cycle();
        check("lat_tvalid_c1", 256'(rr_tvalid), 256'(1'b0));
        check("lat_busy_c1", 256'(rr_busy), 256'(1'b1));
        cycle();
        check("lat_tvalid_c2", 256'(rr_tvalid), 256'(1'b1));
        check("lat_tid_c2", 256'(rr_tid), 256'(2'd2));
        run_drain("lat", 50);
        check("lat_beats", 256'(beats_out), 256'(3));
        check("lat_cnt2", 256'(rr_pkt_cnt[64 +: 32]), 256'(32'd1));

        // Table of single packets with assorted enables and ready patterns.
        foreach (vecs[v]) begin
            chan_en = vecs[v].en;
            rdy_pat = vecs[v].rdy;
            start   = beats_out;
            src_npkt[vecs[v].ch] = 1;
            src_len[vecs[v].ch]  = vecs[v].len;
            drive();
            if (vecs[v].exp_beats > 0) run_drain($sformatf("vec%0d", v), 200);
            else run_cycles(20);
            check($sformatf("vec%0d_beats", v), 256'(beats_out - start), 256'(vecs[v].exp_beats));
            check($sformatf("vec%0d_cnt", v), 256'(rr_pkt_cnt[vecs[v].ch*32 +: 32]), 256'(vecs[v].exp_cnt));
            src_npkt[vecs[v].ch] = 0;
            chan_en = 4'hF;
            rdy_pat = 4'hF;
            drive();
            run_cycles(2);
        end

        // Round-robin fairness with all channels continuously offering.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            src_npkt[i] = 2; src_len[i] = 2;
        end
        drive();
        run_drain("rr", 300);
        check_log("rr", 8, 32'h3210_3210);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr_cnt%0d", i), 256'(rr_pkt_cnt[i*32 +: 32]), 256'(32'd2));
        end

        // Fixed priority: ch0 keeps winning until it drops; 2-bit counter wraps.
        do_reset();
        use_fp = 1'b1;
        src_npkt[0] = 4; src_len[0] = 2;
        src_npkt[1] = 2; src_len[1] = 2;
        drive();
        run_drain("fp", 300);
        check_log("fp", 6, 32'h0011_0000);
        check("fp_cnt0_wrap", 256'(fp_pkt_cnt[1:0]), 256'(2'd0));
        check("fp_cnt1", 256'(fp_pkt_cnt[3:2]), 256'(2'd2));
        use_fp = 1'b0;

        // Disabling a channel mid-packet lets that packet finish, then locks it out.
        do_reset();
        src_npkt[1] = 2; src_len[1] = 4;
        drive();
        n = 0;
        while (!(src_pkt[1] == 0 && src_beat[1] >= 1) && n < 20) begin
            cycle();
            n++;
        end
        check("en_first_beat", 256'(src_beat[1]), 256'(1));
        chan_en = 4'b1101;
        src_npkt[0] = 1; src_len[0] = 2;
        drive();
        run_cycles(40);
        check("en_beats", 256'(beats_out), 256'(6));
        check_log("en", 2, 32'h0000_0001);
        check("en_cnt1", 256'(rr_pkt_cnt[32 +: 32]), 256'(32'd1));
        check("en_cnt0", 256'(rr_pkt_cnt[0 +: 32]), 256'(32'd1));
        src_npkt[1] = 0;
        chan_en = 4'hF;
        drive();
        run_cycles(2);

        // Clear coincident with a tlast accept must win.
        clear_arm = 0;
        src_npkt[0] = 1; src_len[0] = 1;
        drive();
        run_drain("clr", 50);
        clear_arm = -1;
        check("clr_hit", 256'(clear_hits), 256'(1));
        check("clr_cnt0", 256'(rr_pkt_cnt[0 +: 32]), 256'(32'd0));
        check("clr_cnt1", 256'(rr_pkt_cnt[32 +: 32]), 256'(32'd0));

        // Reset asserted mid-packet while the output is stalled.
        src_npkt[3] = 1; src_len[3] = 1;
        drive();
        run_drain("pre_rst", 50);
        check("pre_rst_cnt3", 256'(rr_pkt_cnt[96 +: 32]), 256'(32'd1));
        src_npkt[2] = 1; src_len[2] = 6;
        rdy_pat = 4'h0;
        c2s_tready = 1'b0;
        drive();
        run_cycles(5);
        check("mid_tvalid", 256'(rr_tvalid), 256'(1'b1));
        check("mid_busy", 256'(rr_busy), 256'(1'b1));
        rst = 1'b1;
        #1;
        check("mrst_tvalid", 256'(rr_tvalid), 256'(1'b0));
        check("mrst_in_tready", 256'(rr_in_tready), 256'(4'h0));
        check("mrst_busy", 256'(rr_busy), 256'(1'b0));
        check("mrst_tid", 256'(rr_tid), 256'(2'd0));
        check("mrst_pkt_cnt", 256'(rr_pkt_cnt), 256'(0));
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
